// File: rtl/ni_input_unit.sv
// Receive side of the PE network interface. It buffers router packets in a credit-backed FIFO,
// decodes them into registered PE strobes, and queues READ requests for the output unit.
module ni_input_unit #(
    parameter int FIFO_DEPTH     = 4,
    parameter int RQST_DEPTH     = 4,
    parameter int ACT_ADDR_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_data_valid,
    input  logic [35:0]               in_data,
    output logic                      upstream_credit,
    output logic                      act_recv_en,
    output logic [15:0]               act_recv_addr,
    output logic [15:0]               act_recv_data,
    output logic                      fin_broadcast,
    output logic                      part_sum_recv_en,
    output logic [15:0]               part_sum_recv_addr,
    output logic [15:0]               part_sum_recv_data,
    input  logic                      read_rqst_read_en,
    output logic                      ni_read_rqst,
    output logic [ACT_ADDR_WIDTH-1:0] ni_read_addr,
    output logic                      err_overflow,
    output logic                      err_bad_pkt
);

    localparam logic [3:0] ROUTER_INFO_BROADCAST     = 4'd1;
    localparam logic [3:0] ROUTER_INFO_FIN_BROADCAST = 4'd2;
    localparam logic [3:0] ROUTER_INFO_UV            = 4'd3;
    localparam logic [3:0] ROUTER_INFO_READ          = 4'd4;

    localparam int FP_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FC_W = $clog2(FIFO_DEPTH + 1);
    localparam int RP_W = (RQST_DEPTH > 1) ? $clog2(RQST_DEPTH) : 1;
    localparam int RC_W = $clog2(RQST_DEPTH + 1);

    logic [35:0]               fifo_mem_r [FIFO_DEPTH];
    logic [FP_W-1:0]           fifo_wr_ptr_r;
    logic [FP_W-1:0]           fifo_rd_ptr_r;
    logic [FC_W-1:0]           fifo_cnt_r;
    logic [ACT_ADDR_WIDTH-1:0] rq_mem_r [RQST_DEPTH];
    logic [RP_W-1:0]           rq_wr_ptr_r;
    logic [RP_W-1:0]           rq_rd_ptr_r;
    logic [RC_W-1:0]           rq_cnt_r;

    logic [35:0] head_s;
    logic [3:0]  head_info_s;
    logic        fifo_empty_s;
    logic        fifo_full_s;
    logic        rq_empty_s;
    logic        rq_full_s;
    logic        rq_pop_s;
    logic        rq_push_s;
    logic        fifo_pop_s;
    logic        fifo_push_s;

    // Pop/push qualification; a READ head waits while the request queue has no room.
    always_comb begin
        head_s       = fifo_mem_r[fifo_rd_ptr_r];
        head_info_s  = head_s[35:32];
        fifo_empty_s = (fifo_cnt_r == {FC_W{1'b0}});
        fifo_full_s  = (fifo_cnt_r == FC_W'(FIFO_DEPTH));
        rq_empty_s   = (rq_cnt_r == {RC_W{1'b0}});
        rq_full_s    = (rq_cnt_r == RC_W'(RQST_DEPTH));
        rq_pop_s     = read_rqst_read_en & ~rq_empty_s;
        fifo_pop_s   = ~fifo_empty_s &
                       ~((head_info_s == ROUTER_INFO_READ) & rq_full_s & ~rq_pop_s);
        fifo_push_s  = in_data_valid & (~fifo_full_s | fifo_pop_s);
        rq_push_s    = fifo_pop_s & (head_info_s == ROUTER_INFO_READ);
    end

    // Request queue head; held at zero while the queue is empty.
    always_comb begin
        ni_read_rqst = ~rq_empty_s;
        if (rq_empty_s) begin
            ni_read_addr = {ACT_ADDR_WIDTH{1'b0}};
        end else begin
            ni_read_addr = rq_mem_r[rq_rd_ptr_r];
        end
    end

    // Packet storage; contents are don't-care until the count covers them.
    always_ff @(posedge clk) begin
        if (fifo_push_s) begin
            fifo_mem_r[fifo_wr_ptr_r] <= in_data;
        end
    end

    // Input FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fifo_wr_ptr_r <= {FP_W{1'b0}};
            fifo_rd_ptr_r <= {FP_W{1'b0}};
            fifo_cnt_r    <= {FC_W{1'b0}};
        end else begin
            if (fifo_push_s) begin
                fifo_wr_ptr_r <= (fifo_wr_ptr_r == FP_W'(FIFO_DEPTH - 1)) ? {FP_W{1'b0}}
                                                                          : fifo_wr_ptr_r + 1'b1;
            end
            if (fifo_pop_s) begin
                fifo_rd_ptr_r <= (fifo_rd_ptr_r == FP_W'(FIFO_DEPTH - 1)) ? {FP_W{1'b0}}
                                                                          : fifo_rd_ptr_r + 1'b1;
            end
            case ({fifo_push_s, fifo_pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + 1'b1;
                2'b01:   fifo_cnt_r <= fifo_cnt_r - 1'b1;
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
        end
    end

    // READ request queue; a full queue may push and pop in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rq_wr_ptr_r <= {RP_W{1'b0}};
            rq_rd_ptr_r <= {RP_W{1'b0}};
            rq_cnt_r    <= {RC_W{1'b0}};
            for (int i = 0; i < RQST_DEPTH; i++) begin
                rq_mem_r[i] <= {ACT_ADDR_WIDTH{1'b0}};
            end
        end else begin
            if (rq_push_s) begin
                rq_mem_r[rq_wr_ptr_r] <= head_s[22 +: ACT_ADDR_WIDTH];
                rq_wr_ptr_r <= (rq_wr_ptr_r == RP_W'(RQST_DEPTH - 1)) ? {RP_W{1'b0}}
                                                                      : rq_wr_ptr_r + 1'b1;
            end
            if (rq_pop_s) begin
                rq_rd_ptr_r <= (rq_rd_ptr_r == RP_W'(RQST_DEPTH - 1)) ? {RP_W{1'b0}}
                                                                      : rq_rd_ptr_r + 1'b1;
            end
            case ({rq_push_s, rq_pop_s})
                2'b10:   rq_cnt_r <= rq_cnt_r + 1'b1;
                2'b01:   rq_cnt_r <= rq_cnt_r - 1'b1;
                default: rq_cnt_r <= rq_cnt_r;
            endcase
        end
    end

    // Registered decode: one-cycle strobes plus the credit for every consumed packet.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            upstream_credit    <= 1'b0;
            act_recv_en        <= 1'b0;
            act_recv_addr      <= 16'h0000;
            act_recv_data      <= 16'h0000;
            fin_broadcast      <= 1'b0;
            part_sum_recv_en   <= 1'b0;
            part_sum_recv_addr <= 16'h0000;
            part_sum_recv_data <= 16'h0000;
            err_overflow       <= 1'b0;
            err_bad_pkt        <= 1'b0;
        end else begin
            upstream_credit    <= fifo_pop_s;
            act_recv_en        <= 1'b0;
            act_recv_addr      <= 16'h0000;
            act_recv_data      <= 16'h0000;
            fin_broadcast      <= 1'b0;
            part_sum_recv_en   <= 1'b0;
            part_sum_recv_addr <= 16'h0000;
            part_sum_recv_data <= 16'h0000;
            if (in_data_valid && !fifo_push_s) begin
                err_overflow <= 1'b1;
            end
            if (fifo_pop_s) begin
                case (head_info_s)
                    ROUTER_INFO_BROADCAST: begin
                        act_recv_en   <= 1'b1;
                        act_recv_addr <= head_s[31:16];
                        act_recv_data <= head_s[15:0];
                    end
                    ROUTER_INFO_FIN_BROADCAST: fin_broadcast <= 1'b1;
                    ROUTER_INFO_UV: begin
                        part_sum_recv_en   <= 1'b1;
                        part_sum_recv_addr <= head_s[31:16];
                        part_sum_recv_data <= head_s[15:0];
                    end
                    ROUTER_INFO_READ: err_bad_pkt <= err_bad_pkt;
                    default:          err_bad_pkt <= 1'b1;
                endcase
            end
        end
    end

endmodule

// File: doc/ni_input_unit.md
Name: ni_input_unit

Overview:
- Receive side of the PE network interface: accepts 36-bit packets from the downstream leaf router, buffers them in an input FIFO, and decodes them into PE-controller strobes.
- Returns one credit per consumed packet, which is the counterpart to the output-side credit counter in the router.
- Queues incoming READ requests for the output unit. The output unit pops them via read_rqst_read_en.

Parameters:
- FIFO_DEPTH, 4, input packet FIFO entries; must equal the router's credit count (`TOT_FIFO_DEPTH`).
- RQST_DEPTH, 4, READ request queue entries.
- ACT_ADDR_WIDTH, 6, activation index width (`PeActNoBus`).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset (asserted at 0)
- in_data_valid  in  1  packet valid from router
- in_data  in  36  packet: [35:32] info, [31:16] addr, [15:0] data
- upstream_credit  out  1  one-cycle credit return pulse to router
- act_recv_en  out  1  BROADCAST activation strobe
- act_recv_addr  out  16  activation address (addr field)
- act_recv_data  out  16  activation value
- fin_broadcast  out  1  FIN_BROADCAST strobe
- part_sum_recv_en  out  1  UV partial-sum strobe
- part_sum_recv_addr  out  16  UV addr field
- part_sum_recv_data  out  16  UV data field
- read_rqst_read_en  in  1  pop of READ queue head by output unit
- ni_read_rqst  out  1  READ queue non-empty
- ni_read_addr  out  ACT_ADDR_WIDTH  head request activation index (addr[11:6])
- err_overflow  out  1  sticky: packet arrived with FIFO full and no pop
- err_bad_pkt  out  1  sticky: unsupported info code consumed

Behaviour:
- Reset (rst=0, async) forces the following to 0 and empties both queues:
  - all outputs, including ni_read_addr;
  - both FIFO pointers and counts;
  - both sticky flags.
- Input FIFO write:
  - A packet is written when in_data_valid=1 and the FIFO is not full, or when it is full and a pop occurs in the same cycle (count unchanged).
  - Otherwise the packet is dropped and err_overflow is set.
  - Pointers wrap modulo FIFO_DEPTH.
- Pop condition: FIFO non-empty AND NOT (head info == `ROUTER_INFO_READ` AND READ queue full and not popping this cycle).
  - A blocked READ head stalls the FIFO; there is no reordering.
- Decode is registered. Strobes and data are asserted for exactly one cycle, in the cycle after the pop:
  - BROADCAST: act_recv_en=1, act_recv_addr/act_recv_data = head fields.
  - FIN_BROADCAST: fin_broadcast=1, act_recv_en=0.
  - UV: part_sum_recv_en with its addr/data.
  - READ: push addr[11:6] into the READ queue; no strobe.
  - Any other code (including FIN_COMP): dropped, err_bad_pkt set.
- When no pop occurs, strobes are 0 and data outputs hold 0.
- upstream_credit pulses for 1 cycle in the same cycle as the decoded strobe, i.e. the cycle after each pop, for every info type including dropped ones.
  - Dropped-on-overflow packets return no credit.
- Minimum latency: packet valid at edge N → written; popped in cycle N+1; strobe and credit in cycle N+2.
  - Throughput is 1 packet/cycle when unblocked.
- READ queue:
  - ni_read_rqst = count>0; ni_read_addr = head, combinational from the queue.
  - read_rqst_read_en while empty is ignored.
  - Simultaneous push and pop is legal at any fill level, including full, with count unchanged.
- Reset mid-operation discards all queued packets; credits for them are not returned, and the router resets its counter in the same reset.

Test Plan:
- Reset: rst=0 for 2 cycles → all outputs 0, ni_read_rqst=0.
- Single BROADCAST, addr=0x0005, data=0x1234, at edge N → act_recv_en=1 with 0x0005/0x1234 in cycle N+2, upstream_credit=1 in the same cycle, both 0 in cycle N+3.
- Back-to-back UV, FIN_BROADCAST, BROADCAST on 3 consecutive cycles → part_sum_recv_en, fin_broadcast, act_recv_en on 3 consecutive cycles; exactly 3 credit pulses.
- 5 READ packets (addr[11:6]=1..5) with read_rqst_read_en=0:
  - queue fills with 4 entries; the 5th stalls at the FIFO head and no 5th credit is returned;
  - ni_read_addr=1 at the head;
  - after one read_rqst_read_en pulse, the 5th is enqueued, its credit is returned, and ni_read_addr=2.
- Overflow: hold a READ stall with the FIFO full, then send another packet → err_overflow=1 stays set; the packet is not delivered and no credit is returned.
- Info=`ROUTER_INFO_FIN_COMP` packet → no strobe, err_bad_pkt=1, one credit pulse; then rst=0 asynchronously mid-stream → queues empty and flags cleared immediately.
